// File: rtl/regfile_fwd_pkg.sv
// Shared widths, bus field positions and decode helpers for the decode-stage register file.
// The packed struct layout matches the {we, waddr, wdata} bus so a bus slice casts directly.
package regfile_fwd_pkg;

    localparam int unsigned WbToRfWd  = 38;
    localparam int unsigned ExToIdWd  = 39;
    localparam int unsigned MemToIdWd = 38;
    localparam int unsigned WbToIdWd  = 38;

    localparam int unsigned IsLoadBit = 38;
    localparam int unsigned WeBit     = 37;
    localparam int unsigned WaddrHi   = 36;
    localparam int unsigned WaddrLo   = 32;
    localparam int unsigned WdataHi   = 31;

    localparam int unsigned NumRegs   = 32;
    localparam int unsigned AddrW     = 5;
    localparam int unsigned DataW     = 32;

    typedef logic [AddrW-1:0] reg_addr_t;
    typedef logic [DataW-1:0] reg_data_t;

    typedef struct packed {
        logic      we;
        reg_addr_t waddr;
        reg_data_t wdata;
    } wr_bus_t;

    function automatic wr_bus_t to_wr_bus(logic [WeBit:0] bus);
        return wr_bus_t'(bus);
    endfunction

    // A producer writing $0 never matches, so it can never shadow the hard-wired zero.
    function automatic logic fwd_hit(wr_bus_t src, reg_addr_t raddr);
        return src.we && (src.waddr != '0) && (src.waddr == raddr);
    endfunction

endpackage

// File: rtl/regfile_fwd_if.sv
// Decode-side bundle of the register file: writeback commit, forwarding buses, read ports, stall.
interface regfile_fwd_if;
    import regfile_fwd_pkg::*;

    logic [WbToRfWd-1:0]  wb_to_rf_bus;
    logic [ExToIdWd-1:0]  ex_to_id_fwd;
    logic [MemToIdWd-1:0] mem_to_id_fwd;
    logic [WbToIdWd-1:0]  wb_to_id_fwd;
    logic                 re1;
    logic                 re2;
    reg_addr_t            raddr1;
    reg_addr_t            raddr2;
    reg_data_t            rdata1;
    reg_data_t            rdata2;
    logic                 stallreq_load;

    modport master (
        output wb_to_rf_bus, ex_to_id_fwd, mem_to_id_fwd, wb_to_id_fwd,
        output re1, re2, raddr1, raddr2,
        input  rdata1, rdata2, stallreq_load
    );

    modport slave (
        input  wb_to_rf_bus, ex_to_id_fwd, mem_to_id_fwd, wb_to_id_fwd,
        input  re1, re2, raddr1, raddr2,
        output rdata1, rdata2, stallreq_load
    );

endinterface

// File: rtl/regfile_fwd_fwd_sel.sv
// One read port's operand mux: $0 forces zero, then youngest producer wins (EX > MEM > WB > array).
module regfile_fwd_fwd_sel
    import regfile_fwd_pkg::*;
(
    input  reg_addr_t raddr,
    input  wr_bus_t   ex_src,
    input  wr_bus_t   mem_src,
    input  wr_bus_t   wb_src,
    input  reg_data_t arr_data,
    output reg_data_t rdata
);

    always_comb begin
        rdata = arr_data;
        if (raddr == '0) begin
            rdata = '0;
        end else if (fwd_hit(ex_src, raddr)) begin
            rdata = ex_src.wdata;
        end else if (fwd_hit(mem_src, raddr)) begin
            rdata = mem_src.wdata;
        end else if (fwd_hit(wb_src, raddr)) begin
            rdata = wb_src.wdata;
        end
    end

endmodule

// File: rtl/regfile_fwd.sv
// 32x32 architectural register file with two forwarded read ports and load-use stall request.
// Storage and the stall term live here; each read port's bypass mux is a regfile_fwd_fwd_sel.
module regfile_fwd
    import regfile_fwd_pkg::*;
(
    input logic          clk,
    input logic          rst,
    regfile_fwd_if.slave rf
);

    reg_data_t regs_q [NumRegs];

    wr_bus_t   wr_port;
    wr_bus_t   ex_src;
    wr_bus_t   mem_src;
    wr_bus_t   wb_src;
    logic      ex_is_load;
    reg_data_t arr_data1;
    reg_data_t arr_data2;

    assign wr_port    = to_wr_bus(rf.wb_to_rf_bus[WeBit:0]);
    assign ex_src     = to_wr_bus(rf.ex_to_id_fwd[WeBit:0]);
    assign mem_src    = to_wr_bus(rf.mem_to_id_fwd[WeBit:0]);
    assign wb_src     = to_wr_bus(rf.wb_to_id_fwd[WeBit:0]);
    assign ex_is_load = rf.ex_to_id_fwd[IsLoadBit];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_port.we && (wr_port.waddr != '0)) begin
            regs_q[wr_port.waddr] <= wr_port.wdata;
        end
    end

    // Entry 0 is never read from storage, so it cannot leak X before the first reset.
    always_comb begin
        arr_data1 = '0;
        arr_data2 = '0;
        if (rf.raddr1 != '0) arr_data1 = regs_q[rf.raddr1];
        if (rf.raddr2 != '0) arr_data2 = regs_q[rf.raddr2];
    end

    regfile_fwd_fwd_sel u_sel1 (
        .raddr    (rf.raddr1),
        .ex_src   (ex_src),
        .mem_src  (mem_src),
        .wb_src   (wb_src),
        .arr_data (arr_data1),
        .rdata    (rf.rdata1)
    );

    regfile_fwd_fwd_sel u_sel2 (
        .raddr    (rf.raddr2),
        .ex_src   (ex_src),
        .mem_src  (mem_src),
        .wb_src   (wb_src),
        .arr_data (arr_data2),
        .rdata    (rf.rdata2)
    );

    // A load in EX has no data yet; decode must hold until it reaches MEM.
    always_comb begin
        rf.stallreq_load = 1'b0;
        if (ex_is_load && ex_src.we && (ex_src.waddr != '0)) begin
            rf.stallreq_load = (rf.re1 && (ex_src.waddr == rf.raddr1)) ||
                               (rf.re2 && (ex_src.waddr == rf.raddr2));
        end
    end

endmodule
